// File: rtl/cpu_pkg.sv
// Shared types and default field geometry for the instruction register/decoder.
package cpu_pkg;

    // Instruction register occupancy: nothing held, opcode byte waiting for its
    // immediate byte, or a complete decoded instruction presented to the FSM.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_EXT = 2'd1,
        FULL     = 2'd2
    } ir_state_e;

    localparam int DEF_INSTR_W   = 8;
    localparam int DEF_OP_W      = 2;
    localparam int DEF_REG_SEL_W = 2;
    localparam bit DEF_EXT_EN    = 1'b1;

endpackage

// File: rtl/instr_decode_reg_onehot_dec.sv
// Select-to-one-hot decoder; the whole vector is zero when the enable is low.
module onehot_dec #(
    parameter int SEL_W = 2,
    localparam int NUM  = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NUM-1:0]   vec
);

    // Drive exactly one bit at the selected index when enabled.
    always_comb begin
        vec = {NUM{1'b0}};
        if (en) begin
            vec[sel] = 1'b1;
        end else begin
            vec = {NUM{1'b0}};
        end
    end

endmodule

// File: rtl/instr_decode_reg.sv
// Instruction register/decoder: accepts instruction bytes over valid/ready,
// assembles opcode+immediate pairs and presents registered decoded fields to
// the control FSM, one instruction per out_valid/out_ready handshake.
module instr_decode_reg
    import cpu_pkg::*;
#(
    parameter int               INSTR_W   = DEF_INSTR_W,
    parameter int               OP_W      = DEF_OP_W,
    parameter int               REG_SEL_W = DEF_REG_SEL_W,
    parameter bit               EXT_EN    = DEF_EXT_EN,
    parameter logic [OP_W-1:0]  EXT_OP    = {OP_W{1'b1}},
    localparam int              ADDR_W    = INSTR_W - OP_W - REG_SEL_W,
    localparam int              NUM_REGS  = 1 << REG_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_data,
    output logic                in_ready,
    input  logic                r,
    input  logic                w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_W-1:0]     op,
    output logic [ADDR_W-1:0]   addr,
    output logic [INSTR_W-1:0]  imm,
    output logic                has_imm,
    output logic [NUM_REGS-1:0] ren,
    output logic [NUM_REGS-1:0] wen,
    output logic                flag_zero,
    output logic                illegal
);

    // Everything the register holds about one instruction.
    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [REG_SEL_W-1:0] sel;
        logic [ADDR_W-1:0]    addr;
        logic [INSTR_W-1:0]   imm;
        logic                 has_imm;
        logic                 rd;
        logic                 wr;
        logic                 ill;
        logic                 zero;
    } instr_t;

    ir_state_e           state_r;
    ir_state_e           state_nx_s;
    instr_t              fld_r;
    instr_t              fld_nx_s;
    instr_t              first_s;
    logic                ext_s;
    logic                accept_s;
    logic                out_valid_r;
    logic [NUM_REGS-1:0] ren_r;
    logic [NUM_REGS-1:0] wen_r;
    logic [NUM_REGS-1:0] ren_s;
    logic [NUM_REGS-1:0] wen_s;
    logic                ren_en_s;
    logic                wen_en_s;

    // A held instruction blocks new bytes until the FSM takes it; flush blocks all.
    assign in_ready = !flush && ((state_r != FULL) || out_ready);
    assign accept_s = in_valid && in_ready;

    // Decode the incoming byte as if it were the first byte of an instruction.
    always_comb begin
        first_s.op      = in_data[INSTR_W-1 -: OP_W];
        first_s.sel     = in_data[INSTR_W-OP_W-1 -: REG_SEL_W];
        first_s.addr    = in_data[ADDR_W-1:0];
        first_s.imm     = {INSTR_W{1'b0}};
        first_s.has_imm = 1'b0;
        first_s.rd      = r;
        first_s.wr      = w;
        first_s.ill     = r && w;
        first_s.zero    = (in_data[ADDR_W-1:0] == {ADDR_W{1'b0}});
        ext_s           = EXT_EN && (in_data[INSTR_W-1 -: OP_W] == EXT_OP);
    end

    // Next occupancy and next field contents; flush discards any partial or held instruction.
    always_comb begin
        state_nx_s = state_r;
        fld_nx_s   = fld_r;
        if (flush) begin
            state_nx_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        fld_nx_s   = first_s;
                        state_nx_s = ext_s ? WAIT_EXT : FULL;
                    end else begin
                        state_nx_s = EMPTY;
                    end
                end
                WAIT_EXT: begin
                    if (accept_s) begin
                        fld_nx_s.imm     = in_data;
                        fld_nx_s.has_imm = 1'b1;
                        state_nx_s       = FULL;
                    end else begin
                        state_nx_s = WAIT_EXT;
                    end
                end
                FULL: begin
                    if (out_ready && accept_s) begin
                        fld_nx_s   = first_s;
                        state_nx_s = ext_s ? WAIT_EXT : FULL;
                    end else if (out_ready) begin
                        state_nx_s = EMPTY;
                    end else begin
                        state_nx_s = FULL;
                    end
                end
                default: begin
                    state_nx_s = EMPTY;
                end
            endcase
        end
    end

    // Register enables only exist while a complete, legal instruction is presented.
    assign ren_en_s = (state_nx_s == FULL) && fld_nx_s.rd && !fld_nx_s.ill;
    assign wen_en_s = (state_nx_s == FULL) && fld_nx_s.wr && !fld_nx_s.ill;

    onehot_dec #(.SEL_W(REG_SEL_W)) u_ren_dec (
        .sel (fld_nx_s.sel),
        .en  (ren_en_s),
        .vec (ren_s)
    );

    onehot_dec #(.SEL_W(REG_SEL_W)) u_wen_dec (
        .sel (fld_nx_s.sel),
        .en  (wen_en_s),
        .vec (wen_s)
    );

    // State and all decoded outputs are registered together so the FSM sees a consistent set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            fld_r       <= {$bits(instr_t){1'b0}};
            out_valid_r <= 1'b0;
            ren_r       <= {NUM_REGS{1'b0}};
            wen_r       <= {NUM_REGS{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            fld_r       <= fld_nx_s;
            out_valid_r <= (state_nx_s == FULL);
            ren_r       <= ren_s;
            wen_r       <= wen_s;
        end
    end

    assign out_valid = out_valid_r;
    assign op        = fld_r.op;
    assign addr      = fld_r.addr;
    assign imm       = fld_r.imm;
    assign has_imm   = fld_r.has_imm;
    assign flag_zero = fld_r.zero;
    assign illegal   = fld_r.ill;
    assign ren       = ren_r;
    assign wen       = wen_r;

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: directed scenarios plus a
// randomized stream compared against a byte-level instruction model.
module tb_instr_decode_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       r = 1'b0;
    logic       w = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] imm;
    logic       has_imm;
    logic [3:0] ren;
    logic [3:0] wen;
    logic       flag_zero;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    instr_decode_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .r(r), .w(w), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .addr(addr), .imm(imm), .has_imm(has_imm), .ren(ren), .wen(wen),
        .flag_zero(flag_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [7:0] d, input logic rr, input logic ww,
                          input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        r         = rr;
        w         = ww;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        set_in(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, op, addr, imm, has_imm, ren, wen, flag_zero, illegal} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", {out_valid, op, addr, imm, has_imm, ren, wen, flag_zero, illegal});
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single;
        set_in(1'b1, 8'b01_10_0101, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, op, ren, wen, addr, flag_zero, has_imm, imm} !== {1'b1, 2'd1, 4'b0100, 4'b0000, 4'd5, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL single: v=%b op=%0d ren=%b wen=%b addr=%0d z=%b hi=%b imm=%h, want 1 1 0100 0000 5 0 0 00",
                     out_valid, op, ren, wen, addr, flag_zero, has_imm, imm);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || ren !== 4'b0000) begin
            errors++;
            $display("FAIL single_consume: v=%b ren=%b, want 0 0000", out_valid, ren);
        end
    endtask

    task automatic test_ext;
        set_in(1'b1, 8'b11_01_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || wen !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ext_wait: v=%b wen=%b rdy=%b, want 0 0000 1", out_valid, wen, in_ready);
        end
        set_in(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, op, imm, has_imm, wen, ren, flag_zero} !== {1'b1, 2'd3, 8'hA5, 1'b1, 4'b0010, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL ext_full: v=%b op=%0d imm=%h hi=%b wen=%b ren=%b z=%b, want 1 3 a5 1 0010 0000 1",
                     out_valid, op, imm, has_imm, wen, ren, flag_zero);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [4];
        seq[0] = 8'b00_00_0111;
        seq[1] = 8'b01_01_1000;
        seq[2] = 8'b10_10_1001;
        seq[3] = 8'b00_11_1010;
        set_in(1'b1, 8'b10_11_0011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if ({in_ready, out_valid, op, addr, ren, wen} !== {1'b0, 1'b1, 2'd2, 4'd3, 4'b1000, 4'b0000}) begin
                errors++;
                $display("FAIL stall_%0d: rdy=%b v=%b op=%0d addr=%0d ren=%b wen=%b, want 0 1 2 3 1000 0000",
                         i, in_ready, out_valid, op, addr, ren, wen);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, seq[i], 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || addr !== seq[i][3:0] || op !== seq[i][7:6]) begin
                errors++;
                $display("FAIL stream_%0d: v=%b op=%0d addr=%0d, want 1 %0d %0d", i, out_valid, op, addr, seq[i][7:6], seq[i][3:0]);
            end
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_illegal;
        set_in(1'b1, 8'b00_11_0001, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, illegal, ren, wen, addr} !== {1'b1, 1'b1, 4'b0000, 4'b0000, 4'd1}) begin
            errors++;
            $display("FAIL illegal: v=%b ill=%b ren=%b wen=%b addr=%0d, want 1 1 0000 0000 1",
                     out_valid, illegal, ren, wen, addr);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush;
        set_in(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: rdy=%b, want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: v=%b, want 0", out_valid);
        end
        set_in(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_valid, op, addr, imm, has_imm, ren} !== {1'b1, 2'd1, 4'd2, 8'h00, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL flush_next: v=%b op=%0d addr=%0d imm=%h hi=%b ren=%b, want 1 1 2 00 0 0001",
                     out_valid, op, addr, imm, has_imm, ren);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    // Model: bytes are assembled into instructions; at most one complete
    // instruction is held until the consumer takes it.
    task automatic test_random;
        bit         m_full = 1'b0;
        bit         m_wait = 1'b0;
        logic [7:0] m_b0 = 8'h00;
        logic [7:0] m_imm = 8'h00;
        bit         m_has = 1'b0;
        bit         m_r = 1'b0;
        bit         m_w = 1'b0;
        bit         e_ready;
        bit         e_ill;
        logic [3:0] e_ren;
        logic [3:0] e_wen;
        bit         acc;
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            #1;
            e_ready = !flush && (!m_full || out_ready);
            e_ill   = m_r && m_w;
            e_ren   = (m_full && m_r && !e_ill) ? (4'b0001 << m_b0[5:4]) : 4'b0000;
            e_wen   = (m_full && m_w && !e_ill) ? (4'b0001 << m_b0[5:4]) : 4'b0000;
            checks++;
            if (in_ready !== e_ready || out_valid !== m_full || ren !== e_ren || wen !== e_wen) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d: rdy=%b v=%b ren=%b wen=%b, want %b %b %b %b",
                         c, in_ready, out_valid, ren, wen, e_ready, m_full, e_ren, e_wen);
            end
            if (m_full) begin
                checks++;
                if ({op, addr, imm, has_imm, flag_zero, illegal} !==
                    {m_b0[7:6], m_b0[3:0], m_imm, m_has, m_b0[3:0] == 4'd0, e_ill}) begin
                    errors++;
                    $display("FAIL rand_fields cyc %0d: op=%0d addr=%0d imm=%h hi=%b z=%b ill=%b, want %0d %0d %h %b %b %b",
                             c, op, addr, imm, has_imm, flag_zero, illegal,
                             m_b0[7:6], m_b0[3:0], m_imm, m_has, m_b0[3:0] == 4'd0, e_ill);
                end
            end
            acc = in_valid && e_ready;
            if (flush) begin
                m_full = 1'b0;
                m_wait = 1'b0;
            end else if (m_wait) begin
                if (acc) begin
                    m_imm  = in_data;
                    m_has  = 1'b1;
                    m_wait = 1'b0;
                    m_full = 1'b1;
                end
            end else if (acc) begin
                m_b0  = in_data;
                m_r   = r;
                m_w   = w;
                m_imm = 8'h00;
                m_has = 1'b0;
                if (in_data[7:6] == 2'b11) begin
                    m_wait = 1'b1;
                    m_full = 1'b0;
                end else begin
                    m_full = 1'b1;
                end
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        test_reset();
        test_single();
        test_ext();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
